// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer.
// Each channel: polarity normalisation, 2-flop synchroniser, a consecutive-sample
// stability filter clocked by a shared sample-tick strobe, a debounced level and
// one-cycle press/release pulses.
// Optional long-press detection is built when KEY_DEBOUNCE_LONG_PRESS_EN is defined;
// otherwise key_long is tied to 0 and no hold counters exist.
module key_debounce_multi #(
  parameter int unsigned N_KEYS     = 4,
  parameter int unsigned CLK_DIV    = 10000,
  parameter int unsigned STABLE_CNT = 3,
  parameter bit          ACTIVE_LOW = 1'b0,
  parameter int unsigned LONG_TICKS = 5000
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [N_KEYS-1:0] key_in,
  output logic              sample_tick,
  output logic [N_KEYS-1:0] key_o,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned CntW = $clog2(STABLE_CNT + 1);
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CNT - 1);

  logic [DivW-1:0]             div_q, div_d;
  logic                        tick_q, tick_d;
  logic [N_KEYS-1:0]           s1_q, s1_d;
  logic [N_KEYS-1:0]           s2_q, s2_d;
  logic [N_KEYS-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [N_KEYS-1:0]           ko_q, ko_d;
  logic [N_KEYS-1:0]           press_q, press_d;
  logic [N_KEYS-1:0]           rel_q, rel_d;

  // Prescaler: wrap at CLK_DIV-1 and register the strobe one cycle later.
  always_comb begin
    tick_d = (div_q == DivMax);
    div_d  = tick_d ? '0 : div_q + DivW'(1);
  end

  // Synchroniser input stage with polarity normalised so 1 always means pressed.
  always_comb begin
    s1_d = ACTIVE_LOW ? ~key_in : key_in;
    s2_d = s1_q;
  end

  // Stability filter: a disagreeing sample run of STABLE_CNT ticks flips the level.
  always_comb begin
    cnt_d   = cnt_q;
    ko_d    = ko_q;
    press_d = '0;
    rel_d   = '0;
    if (tick_q) begin
      for (int i = 0; i < int'(N_KEYS); i++) begin
        if (s2_q[i] == ko_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntMax) begin
          ko_d[i]    = s2_q[i];
          cnt_d[i]   = '0;
          press_d[i] = s2_q[i];
          rel_d[i]   = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // State registers for prescaler, synchroniser and filter.
  always_ff @(posedge clk) begin
    if (RST) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      cnt_q   <= '0;
      ko_q    <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      ko_q    <= ko_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign sample_tick = tick_q;
  assign key_o       = ko_q;
  assign key_press   = press_q;
  assign key_release = rel_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned HoldW = $clog2(LONG_TICKS + 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_TICKS);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_TICKS - 1);

  logic [N_KEYS-1:0][HoldW-1:0] hold_q, hold_d;
  logic [N_KEYS-1:0]            long_q, long_d;

  // Hold counter: counts ticks while pressed, saturates, pulses once on arrival.
  always_comb begin
    hold_d = hold_q;
    long_d = '0;
    for (int i = 0; i < int'(N_KEYS); i++) begin
      if (!ko_q[i]) begin
        hold_d[i] = '0;
      end else if (tick_q && (hold_q[i] != HoldMax)) begin
        hold_d[i] = hold_q[i] + HoldW'(1);
        long_d[i] = (hold_q[i] == HoldLast);
      end
    end
  end

  // Hold counter and long-press pulse registers.
  always_ff @(posedge clk) begin
    if (RST) begin
      hold_q <= '0;
      long_q <= '0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign key_long = long_q;
`else
  assign key_long = '0;
`endif

endmodule
